// File: rtl/uart_receiver_if.sv
// Receive-side bus of the UART receiver: serial pin, FIFO read port and status flags.
// The receiver uses the slave modport; the consumer (load/store path or bench) uses master.
interface uart_receiver_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          uart_s_in;
  logic          rd_en;
  logic          clr_err;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [CW-1:0] rx_count;
  logic          frame_err;
  logic          overrun;
  logic          busy;

  modport slave (
    input  uart_s_in, rd_en, clr_err,
    output rx_data, rx_valid, rx_count, frame_err, overrun, busy
  );

  modport master (
    output uart_s_in, rd_en, clr_err,
    input  rx_data, rx_valid, rx_count, frame_err, overrun, busy
  );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling FSM feeding a first-word-fall-through FIFO,
// with sticky framing/overrun flags cleared by software.
module uart_receiver #(
  parameter int BAUD_DIV   = 868,
  parameter int FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  uart_receiver_if.slave bus
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int CNTW = $clog2(BAUD_DIV);
  localparam logic [CNTW-1:0] HALF_LOAD = CNTW'(BAUD_DIV / 2 - 1);
  localparam logic [CNTW-1:0] FULL_LOAD = CNTW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            busy_q;
  logic            s_meta;
  logic            s_sync;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [CW-1:0]   wr_ptr;
  logic [CW-1:0]   rd_ptr;
  logic            full;
  logic            empty;
  logic            pop;
  logic            push;
  logic            wr_ok;
  logic            frame_set;
  logic            overrun_set;
  logic            frame_err_q;
  logic            overrun_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s_meta <= 1'b1;
      s_sync <= 1'b1;
    end else begin
      s_meta <= bus.uart_s_in;
      s_sync <= s_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!s_sync) begin
            cnt    <= HALF_LOAD;
            state  <= S_START;
            busy_q <= 1'b1;
          end
        end
        S_START: begin
          if (cnt != '0) begin
            cnt <= cnt - CNTW'(1);
          end else if (!s_sync) begin
            cnt     <= FULL_LOAD;
            bit_idx <= '0;
            state   <= S_DATA;
          end else begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        end
        S_DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - CNTW'(1);
          end else begin
            shreg[bit_idx] <= s_sync;
            cnt            <= FULL_LOAD;
            if (bit_idx == 3'd7) state <= S_STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end
        end
        S_STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - CNTW'(1);
          end else begin
            // A low stop bit parks in WAIT_HIGH so a held break is not re-read as frames.
            state  <= s_sync ? S_IDLE : S_WAIT_HIGH;
            busy_q <= !s_sync;
          end
        end
        S_WAIT_HIGH: begin
          if (s_sync) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    push        = (state == S_STOP) && (cnt == '0) && s_sync;
    frame_set   = (state == S_STOP) && (cnt == '0) && !s_sync;
    empty       = (wr_ptr == rd_ptr);
    full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop         = bus.rd_en && !empty;
    // A pop in the same cycle frees the slot the push lands in, so a full FIFO still accepts.
    wr_ok       = push && (!full || pop);
    overrun_set = push && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem    <= '{default: '0};
    end else begin
      if (wr_ok) begin
        mem[wr_ptr[AW-1:0]] <= shreg;
        wr_ptr              <= wr_ptr + CW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (frame_set)        frame_err_q <= 1'b1;
      else if (bus.clr_err) frame_err_q <= 1'b0;
      if (overrun_set)      overrun_q   <= 1'b1;
      else if (bus.clr_err) overrun_q   <= 1'b0;
    end
  end

  assign bus.rx_data   = mem[rd_ptr[AW-1:0]];
  assign bus.rx_valid  = !empty;
  assign bus.rx_count  = wr_ptr - rd_ptr;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver at 8 clk/bit, 4-entry FIFO: directed corner cases, a vector
// table for back-to-back/overrun, and random frames checked against a queue model.
module tb_uart_receiver;
  localparam int BAUD  = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  uart_receiver_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_receiver #(
    .BAUD_DIV  (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  byte unsigned model_q[$];
  bit           m_ferr;
  bit           m_ovr;

  typedef struct {
    logic [7:0] data;
    bit         clr;
    int         exp_count;
    bit         exp_ovr;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic drive_bit(input logic v);
    bus.uart_s_in = v;
    repeat (BAUD) @(negedge clk);
  endtask

  // Stop-bit sampling edge is the 7th rising edge after the stop bit is driven.
  task automatic send_frame(input logic [7:0] d, input logic stopbit, input bit pop_at_stop,
                            input bit clr_at_stop, input bit chk_timing);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    bus.uart_s_in = stopbit;
    repeat (BAUD - 2) @(negedge clk);
    if (chk_timing) check("valid_before_stop_edge", bus.rx_valid, 0);
    bus.rd_en   = pop_at_stop;
    bus.clr_err = clr_at_stop;
    @(negedge clk);
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;
    if (chk_timing) check("valid_after_stop_edge", bus.rx_valid, 1);
    @(negedge clk);
  endtask

  task automatic pop_check(input string name, input logic [7:0] expected);
    check({name, "_valid"}, bus.rx_valid, 1);
    check(name, bus.rx_data, expected);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    bit         good;
    int         n;

    tbl[0] = '{8'h01, 1'b0, 1, 1'b0};
    tbl[1] = '{8'h02, 1'b0, 2, 1'b0};
    tbl[2] = '{8'h03, 1'b0, 3, 1'b0};
    tbl[3] = '{8'h04, 1'b0, 4, 1'b0};
    tbl[4] = '{8'h55, 1'b1, 4, 1'b1};

    bus.uart_s_in = 1'b1;
    bus.rd_en     = 1'b0;
    bus.clr_err   = 1'b0;
    rst           = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", bus.rx_valid, 0);
    check("rst_count", bus.rx_count, 0);
    check("rst_data", bus.rx_data, 8'h00);
    check("rst_ferr", bus.frame_err, 0);
    check("rst_ovr", bus.overrun, 0);
    check("rst_busy", bus.busy, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame with exact visibility edge.
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
    check("single_count", bus.rx_count, 1);
    pop_check("single_data", 8'hA5);
    check("single_empty", bus.rx_valid, 0);
    drive_bit(1'b1);

    // Back-to-back frames into a 4-entry FIFO; the fifth overruns even with clr_err on that edge.
    for (int i = 0; i < 5; i++) begin
      send_frame(tbl[i].data, 1'b1, 1'b0, tbl[i].clr, 1'b0);
      check($sformatf("tbl%0d_count", i), bus.rx_count, tbl[i].exp_count);
      check($sformatf("tbl%0d_ovr", i), bus.overrun, tbl[i].exp_ovr);
    end
    for (int i = 0; i < 4; i++) pop_check($sformatf("tbl_pop%0d", i), tbl[i].data);
    check("tbl_drained", bus.rx_valid, 0);
    pulse_clr();
    check("tbl_ovr_cleared", bus.overrun, 0);
    drive_bit(1'b1);

    // Two-cycle glitch: START is entered, then abandoned at the start-bit sample.
    bus.uart_s_in = 1'b0;
    repeat (2) @(negedge clk);
    bus.uart_s_in = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_busy", bus.busy, 1);
    repeat (6) @(negedge clk);
    check("glitch_idle", bus.busy, 0);
    check("glitch_count", bus.rx_count, 0);
    check("glitch_ferr", bus.frame_err, 0);
    check("glitch_ovr", bus.overrun, 0);

    // Full FIFO with a pop on the exact stop-sample edge of the fifth byte.
    for (int i = 1; i <= 4; i++) send_frame(8'(i * 16), 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h50, 1'b1, 1'b1, 1'b0, 1'b0);
    check("simul_count", bus.rx_count, 4);
    check("simul_ovr", bus.overrun, 0);
    for (int i = 2; i <= 5; i++) pop_check($sformatf("simul_pop%0d", i), 8'(i * 16));
    drive_bit(1'b1);

    // Framing error followed by a long break.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (20) drive_bit(1'b0);
    check("break_ferr", bus.frame_err, 1);
    check("break_count", bus.rx_count, 0);
    check("break_busy", bus.busy, 1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    check("break_released", bus.busy, 0);
    send_frame(8'h7E, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_bit(1'b1);
    check("after_break_count", bus.rx_count, 1);
    check("after_break_data", bus.rx_data, 8'h7E);

    // Reset during data bit 3 with a byte queued and frame_err set.
    drive_bit(1'b0);
    repeat (3) drive_bit(1'b1);
    bus.uart_s_in = 1'b1;
    repeat (4) @(negedge clk);
    check("pre_rst_busy", bus.busy, 1);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", bus.rx_valid, 0);
    check("midrst_count", bus.rx_count, 0);
    check("midrst_data", bus.rx_data, 8'h00);
    check("midrst_ferr", bus.frame_err, 0);
    check("midrst_ovr", bus.overrun, 0);
    check("midrst_busy", bus.busy, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    drive_bit(1'b1);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
    check("c3_count", bus.rx_count, 1);
    pop_check("c3_data", 8'hC3);

    // Random frames against a queue model of FIFO contents and sticky flags.
    model_q.delete();
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    for (int it = 0; it < 40; it++) begin
      d    = 8'($urandom);
      good = ($urandom_range(0, 7) != 0);
      send_frame(d, good, 1'b0, 1'b0, 1'b0);
      if (good) begin
        if (model_q.size() < DEPTH) model_q.push_back(d);
        else                        m_ovr = 1'b1;
      end else begin
        m_ferr = 1'b1;
      end
      check("rnd_count", bus.rx_count, model_q.size());
      check("rnd_valid", bus.rx_valid, model_q.size() != 0);
      check("rnd_ferr", bus.frame_err, m_ferr);
      check("rnd_ovr", bus.overrun, m_ovr);
      n = good ? $urandom_range(0, 2) : $urandom_range(1, 2);
      repeat (n) drive_bit(1'b1);
      n = $urandom_range(0, 2);
      for (int j = 0; j < n; j++) begin
        if (model_q.size() != 0) begin
          pop_check("rnd_pop", model_q.pop_front());
        end else begin
          bus.rd_en = 1'b1;
          @(negedge clk);
          bus.rd_en = 1'b0;
          check("rnd_empty_pop", bus.rx_count, 0);
        end
      end
      if ($urandom_range(0, 5) == 0) begin
        pulse_clr();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        check("rnd_clr_ferr", bus.frame_err, 0);
        check("rnd_clr_ovr", bus.overrun, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver for the pipelined RISC-V processor. It is the receive-side counterpart of the processor's UART transmitter and accepts 8N1 frames on the `uart_s_in` pin. Each frame is sampled at mid-bit using a baud-rate counter, and completed bytes are buffered in a small first-word-fall-through FIFO that the load/store path pops. Framing and overrun errors are held in sticky flags until software clears them.

## Interface
- `BAUD_DIV`, default 868: clock cycles per bit (100 MHz / 115200). Must be an even number ≥ 4.
- `FIFO_DEPTH`, default 4: receive FIFO entries. Must be a power of 2, ≥ 2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `uart_s_in` in 1: asynchronous serial input; idle is high.
- `rd_en` in 1: pop the FIFO head. Ignored when the FIFO is empty.
- `clr_err` in 1: clears `frame_err` and `overrun`.
- `rx_data` out 8: FIFO head byte. Valid only while `rx_valid`=1.
- `rx_valid` out 1: FIFO not empty.
- `rx_count` out $clog2(FIFO_DEPTH)+1: FIFO occupancy.
- `frame_err` out 1: sticky flag; a stop bit was sampled as 0.
- `overrun` out 1: sticky flag; a byte was dropped because the FIFO was full.
- `busy` out 1: FSM is not in IDLE.

## Operation
- **Input synchronizer**
  - 2-flop synchronizer on `uart_s_in`; both flops reset to 1.
  - All FSM decisions use the synchronized value `s_sync`.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE:
    - If `s_sync`=0, load `cnt`=BAUD_DIV/2−1 and go to START.
  - START:
    - `cnt` decrements each cycle.
    - At `cnt`=0: if `s_sync`=0, load `cnt`=BAUD_DIV−1, set `bit_idx`=0, go to DATA. Otherwise this is a false start: return to IDLE and push nothing.
  - DATA:
    - At `cnt`=0: shift `s_sync` into bit `bit_idx` (LSB first) and reload `cnt`=BAUD_DIV−1.
    - After bit 7, go to STOP.
  - STOP:
    - At `cnt`=0: if `s_sync`=1, push the shift register into the FIFO and go to IDLE.
    - If `s_sync`=0, set `frame_err`, discard the byte, and go to WAIT_HIGH.
  - WAIT_HIGH:
    - Stay until `s_sync`=1, then go to IDLE. This prevents a break condition from being re-read as back-to-back frames.
- **FIFO**
  - Circular buffer with read and write pointers one bit wider than the address; `rx_data` is driven from `mem[rd_ptr]`.
  - Push while full (and no pop that cycle): the byte is dropped, `overrun` is set, and FIFO contents are unchanged.
  - Simultaneous push and pop when full: both happen, count stays at FIFO_DEPTH, no overrun.
  - Simultaneous push and pop when empty: the push succeeds; the pop is ignored because `rx_valid` was 0.
  - Pointers wrap modulo 2×FIFO_DEPTH.
- **Sticky flags**
  - `clr_err` clears both flags.
  - If a set event and `clr_err` occur in the same cycle, the set wins.
- **Reset**
  - Applies on any cycle, including mid-frame.
  - FSM goes to IDLE, `cnt`/`bit_idx`/shift register go to 0, FIFO is emptied, flags are cleared, synchronizer flops go to 1.
  - A frame interrupted by reset is lost. If the line is still low after reset, it is treated as a new start bit.

## Timing
- **Reset values:** `rx_valid`=0, `rx_count`=0, `rx_data`=8'h00 (memory is cleared), `frame_err`=0, `overrun`=0, `busy`=0.
- **Sampling schedule.** Let t0 be the first rising edge at which `uart_s_in`=0.
  - IDLE sees `s_sync`=0 at edge t0+2; START is entered after that edge.
  - Start bit sampled at t0+2+BAUD_DIV/2.
  - Data bit i sampled at t0+2+BAUD_DIV/2+(i+1)·BAUD_DIV.
  - Stop bit sampled, and FIFO written, at t0+2+BAUD_DIV/2+9·BAUD_DIV.
  - `rx_valid` is high after that edge.
- **Read side**
  - `rx_data` and `rx_valid` are combinational from FIFO state, so there is zero-latency visibility of the head.
  - `rd_en` at edge N makes the next entry visible after edge N.
- **Back-to-back frames:** a start bit beginning immediately after the stop bit is accepted. The receiver returns to IDLE half a bit before the frame ends.
- **Baud tolerance:** at most ±4% mismatch at BAUD_DIV ≥ 16.

## Test plan
All scenarios use BAUD_DIV=8 and FIFO_DEPTH=4, with the bench driving `uart_s_in` at 8 clk/bit.
- **Single frame:** send 8'hA5 → `rx_valid` rises at t0+2+4+72 (+1 cycle visible), `rx_data`=8'hA5, `rx_count`=1; pop with `rd_en` → `rx_valid`=0.
- **Back-to-back and overrun:** send 8'h01, 8'h02, 8'h03, 8'h04, 8'h55 with no reads → `rx_count`=4, `overrun`=1. Pops return 01, 02, 03, 04; 8'h55 is absent. `clr_err` → `overrun`=0.
- **Framing error:** send 8'h3C with stop bit = 0, line held low for 20 more bits, then high → `frame_err`=1, no FIFO write, no extra frames while low. A following 8'h7E is received correctly.
- **False start:** 2-cycle low glitch on an idle line → FSM returns to IDLE at the START sample, `rx_count` stays 0, no flags set.
- **Full FIFO, simultaneous push and pop:** fill 4 bytes, then assert `rd_en` on the exact edge the 5th stop bit is sampled → `rx_count` stays 4, `overrun`=0, order preserved.
- **Reset mid-frame:** assert `rst`=0 during data bit 3 of a frame → all outputs return to reset values on the next edge. The next full frame 8'hC3 is received correctly.
